// File: rtl/irq_pending_arbiter.sv
// Interrupt pending arbiter: rising-edge capture into sticky pending bits,
// masked highest-index select, valid/ack presentation held until EOI.
// Latency: request to irq_valid is 2 cycles (4 with IRQ_SYNC_EN, which adds
// a 2-flop input synchronizer). Backpressure: irq_valid/irq_id hold until irq_ack.
module irq_pending_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   irq_mask,
  input  logic           irq_ack,
  input  logic           irq_eoi,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   pending,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_SERVICE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   irq_d_q, irq_d_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           irq_valid_q, irq_valid_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   edge_src;
  logic [N-1:0]   rise;
  logic [N-1:0]   clr;
  logic [N-1:0]   eligible;
  logic [IDW-1:0] top_idx;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;

  // Two-stage synchronizer ahead of edge detection.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops clear on reset so a held line still yields one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign edge_src = sync2_q;
`else
  assign edge_src = irq_in;
`endif

  assign rise     = edge_src & ~irq_d_q;
  assign eligible = pending_q & ~irq_mask;

  // Highest set eligible bit wins; later loop iterations override earlier.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) top_idx = IDW'(i);
    end
  end

  // Clear strobe for the presented line when the consumer accepts it.
  always_comb begin
    clr = '0;
    if (state_q == S_PRESENT && irq_ack) clr[irq_id_q] = 1'b1;
  end

  // Next-state, pending update and registered output values.
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    irq_d_d     = edge_src;
    // A new edge in the ack cycle keeps the line pending.
    pending_d   = rise | (pending_q & ~clr);
    case (state_q)
      S_IDLE: begin
        if (eligible != '0) begin
          state_d     = S_PRESENT;
          irq_id_d    = top_idx;
          irq_valid_d = 1'b1;
        end
      end
      S_PRESENT: begin
        if (irq_ack) begin
          state_d     = S_SERVICE;
          irq_valid_d = 1'b0;
        end
      end
      S_SERVICE: begin
        irq_valid_d = 1'b0;
        if (irq_eoi) state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        irq_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any handshake in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      irq_d_q     <= '0;
      pending_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_d_q     <= irq_d_d;
      pending_q   <= pending_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      busy_q      <= busy_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Bench for irq_pending_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_irq_pending_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef IRQ_SYNC_EN
  localparam int PL = 3;   // edges from applying a request until pending shows it
`else
  localparam int PL = 1;
`endif
  localparam int SD = PL - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   irq_in, irq_mask;
  logic           irq_ack, irq_eoi;
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic [N-1:0]   pending;
  logic           busy;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  irq_pending_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .irq_mask(irq_mask),
    .irq_ack(irq_ack), .irq_eoi(irq_eoi), .irq_valid(irq_valid),
    .irq_id(irq_id), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing shown, 1 = ID on offer, 2 = being serviced
  bit [N-1:0] m_pend, m_prev;
  int         m_phase, m_id;
  bit         m_on = 1'b0;
  bit [N-1:0] dly[$];

  always @(posedge clk) begin
    bit [N-1:0] seen, rise, elig;
    if (reset) begin
      m_pend = '0; m_prev = '0; m_phase = 0; m_id = 0; m_on = 1'b1;
      dly.delete(); dly.push_back('0); dly.push_back('0);
    end else if (m_on) begin
`ifdef IRQ_SYNC_EN
      dly.push_back(irq_in);
      seen = dly.pop_front();
`else
      seen = irq_in;
`endif
      rise   = seen & ~m_prev;
      m_prev = seen;
      if (m_phase == 0) begin
        elig = m_pend & ~irq_mask;
        if (elig != 0) begin
          for (int i = 0; i < N; i++) if (elig[i]) m_id = i;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (irq_ack) begin m_pend[m_id] = 1'b0; m_phase = 2; end
      end else begin
        if (irq_eoi) m_phase = 0;
      end
      m_pend = m_pend | rise;
    end
    if (m_on) begin
      #1;
      check("model_valid",   irq_valid, (m_phase == 1) ? 1 : 0);
      check("model_pending", pending,   m_pend);
      check("model_busy",    busy,      (m_phase != 0) ? 1 : 0);
      if (m_phase == 1) check("model_id", irq_id, m_id);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(input logic [N-1:0] i, input logic [N-1:0] m,
                     input logic a, input logic e, input logic r);
    irq_in = i; irq_mask = m; irq_ack = a; irq_eoi = e; reset = r;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int exp_id);
    int k = 0;
    while (irq_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, "_valid"}, irq_valid, 1);
    check({name, "_id"}, irq_id, exp_id);
  endtask

  initial begin
    drv('0, '0, 0, 0, 1);
    drv('0, '0, 0, 0, 1);
    check("rst_valid", irq_valid, 0);
    check("rst_pending", pending, 4'b0000);
    check("rst_busy", busy, 0);
    drv('0, '0, 0, 0, 0);

    // single pulse on line 2
    drv(4'b0100, '0, 0, 0, 0);
    repeat (PL - 1) drv('0, '0, 0, 0, 0);
    check("t1_pending", pending, 4'b0100);
    check("t1_valid_early", irq_valid, 0);
    drv('0, '0, 0, 0, 0);
    check("t1_valid", irq_valid, 1);
    check("t1_id", irq_id, 2);
    drv('0, '0, 1, 0, 0);
    check("t1_ack_pending", pending, 4'b0000);
    check("t1_ack_busy", busy, 1);
    drv('0, '0, 0, 1, 0);
    check("t1_eoi_busy", busy, 0);

    // simultaneous rise on lines 3 and 1
    drv(4'b1010, '0, 0, 0, 0);
    drv('0, '0, 0, 0, 0);
    wait_valid("t2_first", 3);
    drv('0, '0, 1, 0, 0);
    check("t2_ack_pending", pending, 4'b0010);
    drv('0, '0, 0, 1, 0);
    wait_valid("t2_second", 1);
    drv('0, '0, 1, 0, 0);
    drv('0, '0, 0, 1, 0);
    repeat (3) drv('0, '0, 0, 0, 0);
    check("t2_final_pending", pending, 4'b0000);
    check("t2_final_valid", irq_valid, 0);

    // masked line 3 stays pending while line 0 is served
    drv(4'b1001, 4'b1000, 0, 0, 0);
    drv('0, 4'b1000, 0, 0, 0);
    wait_valid("t3_line0", 0);
    check("t3_pending", pending, 4'b1001);
    drv('0, 4'b1000, 1, 0, 0);
    check("t3_ack_pending", pending, 4'b1000);
    drv('0, 4'b1000, 0, 1, 0);
    drv('0, '0, 0, 0, 0);
    wait_valid("t3_line3", 3);
    drv('0, '0, 1, 0, 0);
    drv('0, '0, 0, 1, 0);

    // new edge on line 2 lands in the ack cycle
    drv(4'b0100, '0, 0, 0, 0);
    drv('0, '0, 0, 0, 0);
    wait_valid("t4_first", 2);
    repeat (SD) drv(4'b0100, '0, 0, 0, 0);
    drv(4'b0100, '0, 1, 0, 0);
    check("t4_ack_pending", pending, 4'b0100);
    check("t4_ack_valid", irq_valid, 0);
    drv(4'b0100, '0, 0, 1, 0);
    wait_valid("t4_again", 2);
    drv(4'b0100, '0, 1, 0, 0);
    drv('0, '0, 0, 1, 0);
    drv('0, '0, 0, 0, 0);
    check("t4_final_pending", pending, 4'b0000);

    // mask change and higher request during presentation
    drv(4'b0010, '0, 0, 0, 0);
    drv('0, '0, 0, 0, 0);
    wait_valid("t5_first", 1);
    repeat (5) drv(4'b1000, 4'b0010, 0, 0, 0);
    check("t5_hold_valid", irq_valid, 1);
    check("t5_hold_id", irq_id, 1);
    drv(4'b1000, 4'b0010, 1, 0, 0);
    check("t5_ack_pending", pending, 4'b1000);
    drv('0, 4'b0010, 0, 1, 0);
    wait_valid("t5_line3", 3);
    drv('0, '0, 1, 0, 0);
    drv('0, '0, 0, 1, 0);

    // reset in SERVICE, then a line held high across release
    drv(4'b0001, '0, 0, 0, 0);
    drv('0, '0, 0, 0, 0);
    wait_valid("t6_first", 0);
    drv('0, '0, 1, 0, 0);
    drv(4'b1100, '0, 0, 0, 0);
    repeat (PL) drv('0, '0, 0, 0, 0);
    check("t6_pending", pending, 4'b1100);
    check("t6_busy", busy, 1);
    drv(4'b0010, '0, 0, 0, 1);
    check("t6_rst_pending", pending, 4'b0000);
    check("t6_rst_valid", irq_valid, 0);
    check("t6_rst_busy", busy, 0);
    repeat (PL) drv(4'b0010, '0, 0, 0, 0);
    check("t6_rel_early", irq_valid, 0);
    drv(4'b0010, '0, 0, 0, 0);
    check("t6_rel_valid", irq_valid, 1);
    check("t6_rel_id", irq_id, 1);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] ri, rm;
      ri = N'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      drv(($urandom_range(0, 1) == 0) ? ri : irq_in, rm,
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 149) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
